// File: rtl/data_mem_access_unit_if.sv
// Request/response handshake and word-addressed data-memory bus of the MEM-stage load/store unit.
// slave = the access unit; master = pipeline register plus data memory.
interface data_mem_access_unit_if #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 32
);
   logic                  ReqValid;
   logic                  ReqReady;
   logic                  ReqWrite;
   logic [1:0]            ReqSize;
   logic                  ReqSigned;
   logic [31:0]           ReqAddr;
   logic [DATA_WIDTH-1:0] ReqWData;
   logic                  RespValid;
   logic [DATA_WIDTH-1:0] RespData;
   logic                  AddrError;
   logic [ADDR_WIDTH-1:0] MemAddress;
   logic [DATA_WIDTH-1:0] MemWriteData;
   logic                  MemRead;
   logic                  MemWrite;
   logic [DATA_WIDTH-1:0] MemReadData;

   modport slave (
      input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemReadData,
      output ReqReady, RespValid, RespData, AddrError,
      output MemAddress, MemWriteData, MemRead, MemWrite
   );

   modport master (
      output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemReadData,
      input  ReqReady, RespValid, RespData, AddrError,
      input  MemAddress, MemWriteData, MemRead, MemWrite
   );
endinterface

// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store unit: big-endian byte/half/word access, sub-word stores by read-modify-write.
// Optional DMAU_ACCESS_COUNT_EN adds saturating LoadCount/StoreCount outputs.
module data_mem_access_unit #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 32
) (
   input  logic Clk,
   input  logic Reset,
   data_mem_access_unit_if.slave bus
`ifdef DMAU_ACCESS_COUNT_EN
   ,
   output logic [15:0] LoadCount,
   output logic [15:0] StoreCount
`endif
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      STORE  = 3'd2,
      RMW_RD = 3'd3,
      RMW_WR = 3'd4
   } state_t;

   state_t                state_r, nextState_s;
   logic [1:0]            size_r, size_s;
   logic                  signed_r, signed_s;
   logic [1:0]            offset_r, offset_s;
   logic [DATA_WIDTH-1:0] wData_r, wData_s;

   logic                  reqReady_r, reqReady_s;
   logic                  respValid_r, respValid_s;
   logic [DATA_WIDTH-1:0] respData_r, respData_s;
   logic                  addrError_r, addrError_s;
   logic [ADDR_WIDTH-1:0] memAddress_r, memAddress_s;
   logic [DATA_WIDTH-1:0] memWriteData_r, memWriteData_s;
   logic                  memRead_r, memRead_s;
   logic                  memWrite_r, memWrite_s;
   logic                  reqError_s;

   function automatic logic accessError(input logic [1:0] size, input logic [31:0] addr);
      logic err;
      case (size)
         2'b00:   err = 1'b0;
         2'b01:   err = addr[0];
         2'b10:   err = |addr[1:0];
         default: err = 1'b1;
      endcase
      return err | (|addr[31:ADDR_WIDTH+2]);
   endfunction

   function automatic logic [31:0] extractLane(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] offset, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (offset)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      h = offset[1] ? word[15:0] : word[31:16];
      case (size)
         2'b00:   res = sgn ? {{24{b[7]}}, b} : {24'h000000, b};
         2'b01:   res = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
         default: res = word;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] mergeLane(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [1:0] size, input logic [1:0] offset);
      logic [31:0] res;
      res = word;
      case (size)
         2'b00: begin
            case (offset)
               2'd0:    res[31:24] = wdata[7:0];
               2'd1:    res[23:16] = wdata[7:0];
               2'd2:    res[15:8]  = wdata[7:0];
               default: res[7:0]   = wdata[7:0];
            endcase
         end
         2'b01: begin
            if (offset[1]) begin
               res[15:0] = wdata[15:0];
            end else begin
               res[31:16] = wdata[15:0];
            end
         end
         default: res = wdata;
      endcase
      return res;
   endfunction

   assign reqError_s = accessError(bus.ReqSize, bus.ReqAddr);

   // Next state and next values of every registered output.
   always_comb begin
      nextState_s    = state_r;
      size_s         = size_r;
      signed_s       = signed_r;
      offset_s       = offset_r;
      wData_s        = wData_r;
      respValid_s    = 1'b0;
      respData_s     = 32'h0000_0000;
      addrError_s    = 1'b0;
      memAddress_s   = memAddress_r;
      memWriteData_s = memWriteData_r;
      memRead_s      = 1'b0;
      memWrite_s     = 1'b0;

      case (state_r)
         IDLE: begin
            if (bus.ReqValid) begin
               size_s   = bus.ReqSize;
               signed_s = bus.ReqSigned;
               offset_s = bus.ReqAddr[1:0];
               wData_s  = bus.ReqWData;
               // Errors answer straight from IDLE so the flagged pulse lands one cycle after acceptance.
               if (reqError_s) begin
                  respValid_s = 1'b1;
                  addrError_s = 1'b1;
                  nextState_s = IDLE;
               end else begin
                  memAddress_s = bus.ReqAddr[ADDR_WIDTH+1:2];
                  if (!bus.ReqWrite) begin
                     memRead_s   = 1'b1;
                     nextState_s = LOAD;
                  end else if (bus.ReqSize == 2'b10) begin
                     memWrite_s     = 1'b1;
                     memWriteData_s = bus.ReqWData;
                     nextState_s    = STORE;
                  end else begin
                     memRead_s   = 1'b1;
                     nextState_s = RMW_RD;
                  end
               end
            end else begin
               nextState_s = IDLE;
            end
         end
         LOAD: begin
            respValid_s = 1'b1;
            respData_s  = extractLane(bus.MemReadData, size_r, offset_r, signed_r);
            nextState_s = IDLE;
         end
         STORE: begin
            respValid_s = 1'b1;
            nextState_s = IDLE;
         end
         RMW_RD: begin
            memWrite_s     = 1'b1;
            memWriteData_s = mergeLane(bus.MemReadData, wData_r, size_r, offset_r);
            nextState_s    = RMW_WR;
         end
         RMW_WR: begin
            respValid_s = 1'b1;
            nextState_s = IDLE;
         end
         default: begin
            nextState_s = IDLE;
         end
      endcase

      reqReady_s = (nextState_s == IDLE);
   end

   // State, latched request fields and registered outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r        <= IDLE;
         size_r         <= 2'b00;
         signed_r       <= 1'b0;
         offset_r       <= 2'b00;
         wData_r        <= 32'h0000_0000;
         reqReady_r     <= 1'b1;
         respValid_r    <= 1'b0;
         respData_r     <= 32'h0000_0000;
         addrError_r    <= 1'b0;
         memAddress_r   <= '0;
         memWriteData_r <= 32'h0000_0000;
         memRead_r      <= 1'b0;
         memWrite_r     <= 1'b0;
      end else begin
         state_r        <= nextState_s;
         size_r         <= size_s;
         signed_r       <= signed_s;
         offset_r       <= offset_s;
         wData_r        <= wData_s;
         reqReady_r     <= reqReady_s;
         respValid_r    <= respValid_s;
         respData_r     <= respData_s;
         addrError_r    <= addrError_s;
         memAddress_r   <= memAddress_s;
         memWriteData_r <= memWriteData_s;
         memRead_r      <= memRead_s;
         memWrite_r     <= memWrite_s;
      end
   end

`ifdef DMAU_ACCESS_COUNT_EN
   logic [15:0] loadCount_r, storeCount_r;

   // Saturating counters of successful accesses, stepped on the edge that raises RespValid.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         loadCount_r  <= 16'h0000;
         storeCount_r <= 16'h0000;
      end else begin
         if ((state_r == LOAD) && (loadCount_r != 16'hFFFF)) begin
            loadCount_r <= loadCount_r + 16'd1;
         end else begin
            loadCount_r <= loadCount_r;
         end
         if (((state_r == STORE) || (state_r == RMW_WR)) && (storeCount_r != 16'hFFFF)) begin
            storeCount_r <= storeCount_r + 16'd1;
         end else begin
            storeCount_r <= storeCount_r;
         end
      end
   end

   assign LoadCount  = loadCount_r;
   assign StoreCount = storeCount_r;
`endif

   // Strobes are forced low during reset so an interrupted read-modify-write never lands.
   assign bus.MemRead      = memRead_r & ~Reset;
   assign bus.MemWrite     = memWrite_r & ~Reset;
   assign bus.MemAddress   = memAddress_r;
   assign bus.MemWriteData = memWriteData_r;
   assign bus.ReqReady     = reqReady_r;
   assign bus.RespValid    = respValid_r;
   assign bus.RespData     = respData_r;
   assign bus.AddrError    = addrError_r;

endmodule
